// File: rtl/riscv_types.sv
// Shared RISC-V execute-stage types: datapath width, register address, ALU operand
// bundle and the ALU issue-port identifiers.
package riscv_types;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned NUM_ALU_PORTS = 2;

  typedef logic [4:0] rs_addr_t;
  typedef logic [$clog2(NUM_ALU_PORTS)-1:0] alu_port_id_t;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e         op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
  } alu_inputs_t;

  // Encode a one-hot (or all-zero) port vector into a port index; all-zero maps to 0.
  function automatic alu_port_id_t onehot_to_port(input logic [NUM_ALU_PORTS-1:0] oh);
    alu_port_id_t port;
    port = '0;
    for (int unsigned i = 0; i < NUM_ALU_PORTS; i++) begin
      if (oh[i]) begin
        port = alu_port_id_t'(i);
      end
    end
    return port;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among the requesters, favouring the one after the
// last granted requester. The last-grant pointer moves only when the grant is consumed.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IdxW-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] pick;
  logic               found;

  // Requesters strictly above the last grant take priority; otherwise wrap to the lowest.
  always_comb begin
    hi_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (IdxW'(i) > last_q);
    end
    req_hi = req & hi_mask;
    pick   = (req_hi != '0) ? req_hi : req;
  end

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    if (enable) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (pick[i] && !found) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          last_d = IdxW'(i);
        end
      end
    end
  end

  // Reset points at the highest requester so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IdxW'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

  grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  grant_req_a:    assert property (@(posedge clk) disable iff (rst) (gnt & ~req) == '0);

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one external ALU between two issue ports: round-robin grant, payload mux to the
// ALU, and a single-entry writeback register with ready/valid handshake.
module alu_issue_arbiter
  import riscv_types::*;
#(
  parameter int unsigned NUM_PORTS = NUM_ALU_PORTS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic        [NUM_PORTS-1:0] req_valid,
  output logic        [NUM_PORTS-1:0] req_ready,
  input  alu_inputs_t [NUM_PORTS-1:0] req_op,
  input  logic        [NUM_PORTS-1:0] req_rd_en,
  input  rs_addr_t    [NUM_PORTS-1:0] req_rd_addr,
  output alu_inputs_t                 alu_op_o,
  output logic                        alu_rd_en_o,
  input  logic        [XLEN-1:0]      alu_rd_data_i,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic        [XLEN-1:0]      wb_data,
  output rs_addr_t                    wb_rd_addr,
  output alu_port_id_t                wb_src
);

  if (NUM_PORTS != NUM_ALU_PORTS) begin : g_bad_num_ports
    $error("alu_issue_arbiter supports exactly NUM_ALU_PORTS requesters");
  end

  logic [NUM_PORTS-1:0] grant;
  logic                 issue_en;
  logic                 issue_fire;

  alu_inputs_t          sel_op;
  logic                 sel_rd_en;
  rs_addr_t             sel_rd_addr;
  alu_port_id_t         sel_src;

  logic                 wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  rs_addr_t             wb_rd_addr_q, wb_rd_addr_d;
  alu_port_id_t         wb_src_q, wb_src_d;

  // Issue only when the writeback slot is free or being drained this cycle.
  assign issue_en = !rst && (!wb_valid_q || wb_ready);

  rr_arbiter #(
    .NUM_REQ (NUM_PORTS)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .enable  (issue_en),
    .advance (issue_fire),
    .gnt     (grant)
  );

  assign req_ready  = grant;
  assign issue_fire = |(req_valid & grant);

  always_comb begin
    sel_op      = '0;
    sel_rd_en   = 1'b0;
    sel_rd_addr = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_op      = req_op[i];
        sel_rd_en   = req_rd_en[i];
        sel_rd_addr = req_rd_addr[i];
      end
    end
    sel_src = onehot_to_port(grant);
  end

  assign alu_op_o    = sel_op;
  assign alu_rd_en_o = sel_rd_en;

  // A non-writing issue still drains a ready slot; it simply leaves nothing behind.
  always_comb begin
    wb_valid_d   = wb_valid_q;
    wb_data_d    = wb_data_q;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_src_d     = wb_src_q;
    if (issue_fire && sel_rd_en) begin
      wb_valid_d   = 1'b1;
      wb_data_d    = alu_rd_data_i;
      wb_rd_addr_d = sel_rd_addr;
      wb_src_d     = sel_src;
    end else if (wb_ready) begin
      wb_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_addr_q <= '0;
      wb_src_q     <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_src_q     <= wb_src_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_rd_addr = wb_rd_addr_q;
  assign wb_src     = wb_src_q;

  stall_no_grant_a: assert property (@(posedge clk) disable iff (rst)
    (wb_valid_q && !wb_ready) -> (grant == '0));

endmodule

// File: doc/alu_issue_arbiter.md
ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
REQ-001 Parameter: NUM_PORTS, default 2, number of requesters sharing the one ALU; only 2 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  [NUM_PORTS]  per-port request valid.
REQ-005 req_ready  output  [NUM_PORTS]  per-port grant; a transfer occurs when valid && ready.
REQ-006 req_op  input  alu_inputs_t[NUM_PORTS]  per-port ALU operand/control bundle.
REQ-007 req_rd_en  input  [NUM_PORTS]  per-port result-writeback enable.
REQ-008 req_rd_addr  input  rs_addr_t[NUM_PORTS]  per-port destination register.
REQ-009 alu_op_o  output  alu_inputs_t  bundle driven to the shared ALU.
REQ-010 alu_rd_en_o  output  1  rd enable driven to the ALU.
REQ-011 alu_rd_data_i  input  XLEN (32)  combinational ALU result for alu_op_o in the same cycle.
REQ-012 wb_valid  output  1  writeback stage holds a result.
REQ-013 wb_ready  input  1  consumer accepts the writeback when wb_valid && wb_ready.
REQ-014 wb_data  output  XLEN  registered result.
REQ-015 wb_rd_addr  output  rs_addr_t  registered destination.
REQ-016 wb_src  output  1  index of the port that issued the result.

Function
REQ-017 The block SHALL grant at most one port per cycle, and only when the wb stage can accept: the stage is empty (!wb_valid) or is draining this cycle (wb_ready).
REQ-018 Arbitration SHALL be round-robin: with both ports valid, the port not granted last wins; with one port valid, that port wins.
REQ-019 The last-grant pointer SHALL update only on an accepted transfer.
REQ-020 req_ready SHALL be a combinational function of req_valid, wb_valid, wb_ready and the pointer; it SHALL NOT depend on req_op.
REQ-021 Requesters SHALL hold valid and payload stable until accepted; the block SHALL NOT buffer un-granted requests.
REQ-022 alu_op_o and alu_rd_en_o SHALL carry the granted port's payload; with no grant, both SHALL be all-zero.
REQ-023 Latency: a transfer accepted with rd_en=1 in cycle N SHALL present wb_valid=1 in cycle N+1, with wb_data = alu_rd_data_i sampled at N, plus the matching rd_addr and src.
REQ-024 A transfer accepted with rd_en=0 SHALL consume the ALU cycle and advance the pointer, but SHALL NOT set wb_valid.
REQ-025 While wb_valid && !wb_ready, all wb_* outputs SHALL hold stable and req_ready SHALL be all-zero.
REQ-026 Simultaneous drain and accept (wb_ready=1 and a new rd_en=1 transfer) SHALL replace the wb contents with no bubble, sustaining one result per cycle.
REQ-027 Drain with no new rd_en=1 transfer SHALL clear wb_valid in the next cycle.

Reset
REQ-028 On rst, the block SHALL set wb_valid=0, wb_data=0, wb_rd_addr=0, wb_src=0, and set the pointer to last-grant = port 1, so port 0 wins first.
REQ-029 While rst is high, req_ready SHALL be 0 and alu_op_o SHALL be zero; an in-flight wb result is discarded.

Structure
REQ-030 The shared package riscv_types SHALL hold XLEN, rs_addr_t, alu_inputs_t and the new constant NUM_ALU_PORTS and type alu_port_id_t.
REQ-031 Round-robin selection SHALL be a sub-module, rr_arbiter, with inputs request vector, enable and advance, and outputs a one-hot grant; the pointer lives inside rr_arbiter.
REQ-032 The ALU SHALL be instantiated outside this block; the block only sequences it.

Verification
REQ-033 Reset, then both ports valid with rd_en=1 for 4 cycles and wb_ready=1 -> grants 0,1,0,1; wb_src 0,1,0,1 from cycle 2; one result per cycle.
REQ-034 Port 0 only: ADD 5+7, rd_addr=3 -> next cycle wb_valid=1, wb_data=12, wb_rd_addr=3, wb_src=0.
REQ-035 wb_ready=0 for 3 cycles with both ports valid -> wb_* stable, req_ready=00 throughout; on wb_ready=1, the next grant goes to the port not last granted.
REQ-036 Port 1 SUB 3-5 with rd_en=0 -> ALU driven for one cycle, wb_valid stays 0; the next contended grant goes to port 0.
REQ-037 rst asserted the cycle after a grant, with wb_valid pending -> wb_valid=0 next cycle; after reset, port 0 wins first.
REQ-038 Random valid/ready stress over 10k cycles -> no lost or duplicated results, per-port order preserved, and no port waits more than 2 accepted transfers while valid.
